// File: rtl/bus_arbiter3.sv
// Round-robin arbiter sharing one 32-bit bus among three requesters.
// Drives registered one-hot grants, the 3:1 mux select and busy; a hold limit bounds contended ownership.
module bus_arbiter3 #(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 5
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [2:0] req,
   output logic [2:0] grant,
   output logic [1:0] sel,
   output logic       busy
);

   typedef enum logic [0:0] {IDLE = 1'b0, OWN = 1'b1} state_t;

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_HOLD = CNT_W'(MAX_HOLD);

   state_t           state_r, state_n;
   logic [1:0]       owner_r, owner_n;
   logic [1:0]       ptr_r, ptr_n;
   logic [CNT_W-1:0] cnt_r, cnt_n;
   logic [2:0]       grant_r, grant_n;
   logic [1:0]       sel_r, sel_n;
   logic             busy_r, busy_n;
   logic [2:0]       others_s;
   logic             owner_req_s;

   function automatic logic [1:0] inc3(input logic [1:0] i);
      case (i)
         2'd0:    inc3 = 2'd1;
         2'd1:    inc3 = 2'd2;
         default: inc3 = 2'd0;
      endcase
   endfunction

   function automatic logic bit3(input logic [2:0] r, input logic [1:0] i);
      case (i)
         2'd0:    bit3 = r[0];
         2'd1:    bit3 = r[1];
         2'd2:    bit3 = r[2];
         default: bit3 = 1'b0;
      endcase
   endfunction

   function automatic logic [2:0] onehot3(input logic [1:0] i);
      case (i)
         2'd0:    onehot3 = 3'b001;
         2'd1:    onehot3 = 3'b010;
         2'd2:    onehot3 = 3'b100;
         default: onehot3 = 3'b000;
      endcase
   endfunction

   // Mux select encoding is fixed by the bus mux wiring, not by requester index.
   function automatic logic [1:0] sel_code(input logic [1:0] i);
      case (i)
         2'd0:    sel_code = 2'b10;
         2'd1:    sel_code = 2'b11;
         default: sel_code = 2'b00;
      endcase
   endfunction

   // First set request scanning upward (mod 3) from start; caller guarantees r != 0.
   function automatic logic [1:0] pick3(input logic [2:0] r, input logic [1:0] start);
      if (bit3(r, start)) begin
         pick3 = start;
      end else if (bit3(r, inc3(start))) begin
         pick3 = inc3(start);
      end else begin
         pick3 = inc3(inc3(start));
      end
   endfunction

   // Next-state, ownership, round-robin pointer and hold counter decisions.
   always_comb begin
      state_n     = state_r;
      owner_n     = owner_r;
      ptr_n       = ptr_r;
      cnt_n       = cnt_r;
      grant_n     = grant_r;
      sel_n       = sel_r;
      busy_n      = busy_r;
      others_s    = req & ~onehot3(owner_r);
      owner_req_s = bit3(req, owner_r);

      case (state_r)
         IDLE: begin
            if (|req) begin
               state_n = OWN;
               owner_n = pick3(req, ptr_r);
               cnt_n   = CNT_ONE;
            end else begin
               state_n = IDLE;
            end
         end
         OWN: begin
            // Release takes precedence over the hold limit when both happen together.
            if (!owner_req_s || (cnt_r == CNT_HOLD)) begin
               if (|others_s) begin
                  owner_n = pick3(others_s, inc3(owner_r));
                  ptr_n   = inc3(owner_r);
                  cnt_n   = CNT_ONE;
               end else if (!owner_req_s) begin
                  state_n = IDLE;
                  ptr_n   = inc3(owner_r);
               end else begin
                  cnt_n   = CNT_ONE;
               end
            end else begin
               cnt_n = cnt_r + CNT_ONE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      // sel keeps the last owner's code while idle.
      if (state_n == OWN) begin
         grant_n = onehot3(owner_n);
         sel_n   = sel_code(owner_n);
         busy_n  = 1'b1;
      end else begin
         grant_n = 3'b000;
         sel_n   = sel_r;
         busy_n  = 1'b0;
      end
   end

   // State and registered outputs; async reset drops any grant immediately.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
         owner_r <= 2'd0;
         ptr_r   <= 2'd0;
         cnt_r   <= '0;
         grant_r <= 3'b000;
         sel_r   <= 2'b00;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_n;
         owner_r <= owner_n;
         ptr_r   <= ptr_n;
         cnt_r   <= cnt_n;
         grant_r <= grant_n;
         sel_r   <= sel_n;
         busy_r  <= busy_n;
      end
   end

   assign grant = grant_r;
   assign sel   = sel_r;
   assign busy  = busy_r;

endmodule
